// File: rtl/ms_dec_vliw_pipe.sv
// Registered VLIW decode merge: selects one ISA decoder by CPU type, owns the
// multi-step sequencing register, arbitrates unity steps and buffers bundles in a 2-deep FIFO.
//
// state | meaning
// IDLE  | issuing plain steps; unity steps raise a request and move to WAIT
// WAIT  | unity request outstanding; the step issues on the first ack with FIFO space
module ms_dec_vliw_pipe #(
  parameter int CHANNELS = 2,
  parameter int VLIW_W   = 128,
  parameter int STEP_W   = 10,
  parameter int TYPE_W   = 2
) (
  input  logic                         AClkH,
  input  logic                         AResetH,
  input  logic [TYPE_W-1:0]            ACpuType,
  input  logic [CHANNELS*VLIW_W-1:0]   AChVliw,
  input  logic [CHANNELS*2-1:0]        AChCmdLen,
  input  logic [CHANNELS*STEP_W-1:0]   AChStepNext,
  input  logic [CHANNELS-1:0]          AChUnityReq,
  input  logic                         AInValid,
  output logic                         AInPop,
  output logic [STEP_W-1:0]            AStepThis,
  output logic                         AUnityReq,
  input  logic                         AUnityAck,
  input  logic                         AFlush,
  output logic                         AOutValid,
  input  logic                         AOutReady,
  output logic [VLIW_W-1:0]            AOutVliw,
  output logic [1:0]                   AOutCmdLen,
  output logic [STEP_W-1:0]            AOutStep,
  output logic                         AErrType
);

  localparam int ENT_W = VLIW_W + 2 + STEP_W;

  typedef enum logic {sIdle = 1'b0, sWait = 1'b1} stateT;

  stateT              state;
  stateT              stateNext;
  logic               selValid;
  logic [VLIW_W-1:0]  selVliw;
  logic [1:0]         selLen;
  logic [STEP_W-1:0]  selNext;
  logic               selUnity;
  logic               lastStep;
  logic               accept;
  logic               space;
  logic               fifoPop;
  logic [ENT_W-1:0]   fifoMem [2];
  logic [ENT_W-1:0]   pushEntry;
  logic [ENT_W-1:0]   head;
  logic               wrPtr;
  logic               rdPtr;
  logic [1:0]         count;

  // Channel selection; an out-of-range CPU type yields an all-zero selection.
  always_comb begin
    selValid = (int'(ACpuType) < CHANNELS);
    selVliw  = '0;
    selLen   = '0;
    selNext  = '0;
    selUnity = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (selValid && int'(ACpuType) == k) begin
        selVliw  = AChVliw[k*VLIW_W +: VLIW_W];
        selLen   = AChCmdLen[k*2 +: 2];
        selNext  = AChStepNext[k*STEP_W +: STEP_W];
        selUnity = AChUnityReq[k];
      end
    end
  end

  assign lastStep  = (selNext == '0);
  assign AOutValid = (count != 2'd0);
  assign fifoPop   = AOutValid & AOutReady;
  assign space     = (count < 2'd2) | fifoPop;

  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) begin
      state <= sIdle;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    if (AFlush) begin
      stateNext = sIdle;
    end else begin
      case (state)
        sIdle:   if (AInValid && selValid && selUnity) stateNext = sWait;
        sWait:   if (accept) stateNext = sIdle;
        default: stateNext = sIdle;
      endcase
    end
  end

  always_comb begin
    accept = 1'b0;
    if (!AResetH && !AFlush && AInValid && selValid && space) begin
      case (state)
        sIdle:   accept = !selUnity;
        sWait:   accept = AUnityAck;
        default: accept = 1'b0;
      endcase
    end
  end

  assign AInPop    = accept & lastStep;
  assign AUnityReq = (state == sWait);

  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) begin
      AStepThis <= '0;
      AErrType  <= 1'b0;
    end else if (AFlush) begin
      AStepThis <= '0;
      AErrType  <= 1'b0;
    end else begin
      if (accept) AStepThis <= selNext;
      if (AInValid && !selValid) AErrType <= 1'b1;
    end
  end

  // Only the cmd-len of the final step is forwarded, so execute sees one length per command.
  assign pushEntry = {selVliw, (lastStep ? selLen : 2'b00), AStepThis};

  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) begin
      fifoMem[0] <= '0;
      fifoMem[1] <= '0;
      wrPtr      <= 1'b0;
      rdPtr      <= 1'b0;
      count      <= 2'd0;
    end else if (AFlush) begin
      wrPtr <= 1'b0;
      rdPtr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (accept) begin
        fifoMem[wrPtr] <= pushEntry;
        wrPtr          <= ~wrPtr;
      end
      if (fifoPop) rdPtr <= ~rdPtr;
      count <= count + {1'b0, accept} - {1'b0, fifoPop};
    end
  end

  assign head       = fifoMem[rdPtr];
  assign AOutVliw   = head[ENT_W-1 -: VLIW_W];
  assign AOutCmdLen = head[STEP_W +: 2];
  assign AOutStep   = head[STEP_W-1:0];

endmodule

// File: tb/tb_ms_dec_vliw_pipe.sv
// Bench for ms_dec_vliw_pipe: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_ms_dec_vliw_pipe;

  localparam int CH = 2;
  localparam int VW = 128;
  localparam int SW = 10;
  localparam int TW = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [TW-1:0]     ACpuType = '0;
  logic [CH*VW-1:0]  chVliw;
  logic [CH*2-1:0]   chLen;
  logic [CH*SW-1:0]  chNext;
  logic [CH-1:0]     chUnity;
  logic              AInValid = 1'b0;
  logic              AInPop;
  logic [SW-1:0]     AStepThis;
  logic              AUnityReq;
  logic              AUnityAck = 1'b0;
  logic              AFlush = 1'b0;
  logic              AOutValid;
  logic              AOutReady = 1'b0;
  logic [VW-1:0]     AOutVliw;
  logic [1:0]        AOutCmdLen;
  logic [SW-1:0]     AOutStep;
  logic              AErrType;

  int nAssert = 0;
  int nFail   = 0;

  always #5 clk = ~clk;

  ms_dec_vliw_pipe #(.CHANNELS(CH), .VLIW_W(VW), .STEP_W(SW), .TYPE_W(TW)) dut (
    .AClkH(clk), .AResetH(rst), .ACpuType(ACpuType), .AChVliw(chVliw),
    .AChCmdLen(chLen), .AChStepNext(chNext), .AChUnityReq(chUnity),
    .AInValid(AInValid), .AInPop(AInPop), .AStepThis(AStepThis),
    .AUnityReq(AUnityReq), .AUnityAck(AUnityAck), .AFlush(AFlush),
    .AOutValid(AOutValid), .AOutReady(AOutReady), .AOutVliw(AOutVliw),
    .AOutCmdLen(AOutCmdLen), .AOutStep(AOutStep), .AErrType(AErrType)
  );

  // Decoder stand-in: a program is a list of step values; each channel decodes the same list.
  int         progSteps [8];
  int         progCnt = 1;
  logic [1:0] progLen = 2'd0;
  logic [7:0] progUnity = '0;
  int         decIdx;

  function automatic logic [VW-1:0] vliwOf(input int k, input logic [SW-1:0] s);
    return {16'hC0DE, 16'(k), 22'd0, s, 64'h0123_4567_89AB_CDEF};
  endfunction

  function automatic int findIdx(input logic [SW-1:0] s);
    for (int i = 0; i < 8; i++)
      if (i < progCnt && progSteps[i] == int'(s)) return i;
    return -1;
  endfunction

  always_comb begin
    chVliw  = '0;
    chLen   = '0;
    chNext  = '0;
    chUnity = '0;
    decIdx  = findIdx(AStepThis);
    for (int k = 0; k < CH; k++) begin
      chVliw[k*VW +: VW] = vliwOf(k, AStepThis);
      chLen[k*2 +: 2]    = progLen;
      if (decIdx >= 0) begin
        chNext[k*SW +: SW] = (decIdx + 1 < progCnt) ? SW'(progSteps[decIdx+1]) : '0;
        chUnity[k]         = progUnity[decIdx];
      end
    end
  end

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue of issued steps, plus sequencing state.
  typedef struct {
    logic [VW-1:0] v;
    logic [1:0]    l;
    logic [SW-1:0] s;
  } entT;

  entT  mQ [$];
  int   mStep = 0;
  bit   mWait = 0;
  bit   mErr  = 0;

  always @(negedge clk) begin : model
    bit            selOk, ureq, acc, space;
    logic [SW-1:0] nxt;
    logic [VW-1:0] v;
    logic [1:0]    l;
    entT           e;
    selOk = int'(ACpuType) < CH;
    ureq  = selOk ? chUnity[ACpuType] : 1'b0;
    nxt   = selOk ? chNext[int'(ACpuType)*SW +: SW] : '0;
    v     = selOk ? chVliw[int'(ACpuType)*VW +: VW] : '0;
    l     = selOk ? chLen[int'(ACpuType)*2 +: 2] : 2'd0;
    space = (mQ.size() < 2) || (mQ.size() > 0 && AOutReady);
    acc   = 0;
    if (!rst && !AFlush && AInValid && selOk && space)
      acc = mWait ? AUnityAck : !ureq;

    chk("m outValid", AOutValid, mQ.size() > 0);
    if (mQ.size() > 0) begin
      chk("m outVliw", AOutVliw, mQ[0].v);
      chk("m outLen", AOutCmdLen, mQ[0].l);
      chk("m outStep", AOutStep, mQ[0].s);
    end
    chk("m stepThis", AStepThis, mStep);
    chk("m unityReq", AUnityReq, mWait);
    chk("m errType", AErrType, mErr);
    chk("m inPop", AInPop, acc && nxt == '0);

    if (rst || AFlush) begin
      mQ.delete();
      mStep = 0;
      mWait = 0;
      mErr  = 0;
    end else begin
      if (AInValid && !selOk) mErr = 1;
      if (mQ.size() > 0 && AOutReady) void'(mQ.pop_front());
      if (acc) begin
        e.v = v;
        e.l = (nxt == '0) ? l : 2'd0;
        e.s = SW'(mStep);
        mQ.push_back(e);
        mStep = int'(nxt);
      end
      if (mWait && acc) mWait = 0;
      else if (!mWait && AInValid && selOk && ureq) mWait = 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setProg(input int s0, input int s1, input int s2, input int s3,
                         input int cnt, input logic [1:0] len, input logic [7:0] uni);
    progSteps[0] = s0;
    progSteps[1] = s1;
    progSteps[2] = s2;
    progSteps[3] = s3;
    progCnt      = cnt;
    progLen      = len;
    progUnity    = uni;
  endtask

  task automatic runCmd(input logic [15:0] rdyPat, input int maxc);
    bit done;
    done = 0;
    AInValid = 1'b1;
    for (int i = 0; i < maxc && !done; i++) begin
      AOutReady = rdyPat[i % 16];
      #1;
      done = AInPop;
      tick();
    end
    AInValid = 1'b0;
    nAssert++;
    if (!done) begin
      nFail++;
      $display("FAIL runCmd: got no pop, expected pop within %0d cycles", maxc);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int reqCycles;
    for (int i = 0; i < 8; i++) progSteps[i] = 0;
    setProg(0, 0, 0, 0, 1, 2'd2, 8'h00);

    // Reset: a valid single-step command must not pop while reset is held.
    ACpuType = 2'd1;
    AInValid = 1'b1;
    repeat (2) tick();
    #1;
    chk("rst inPop", AInPop, 1'b0);
    chk("rst outValid", AOutValid, 1'b0);
    chk("rst stepThis", AStepThis, '0);
    chk("rst unityReq", AUnityReq, 1'b0);
    chk("rst outVliw", AOutVliw, '0);
    chk("rst outLen", AOutCmdLen, '0);
    chk("rst outStep", AOutStep, '0);
    chk("rst errType", AErrType, 1'b0);
    AInValid = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Single-step command on channel 1.
    AOutReady = 1'b1;
    AInValid  = 1'b1;
    #1;
    chk("t1 inPop", AInPop, 1'b1);
    tick();
    AInValid = 1'b0;
    #1;
    chk("t1 outValid", AOutValid, 1'b1);
    chk("t1 outLen", AOutCmdLen, 2'd2);
    chk("t1 outStep", AOutStep, 10'd0);
    chk("t1 outVliw", AOutVliw, vliwOf(1, 10'd0));
    chk("t1 inPop off", AInPop, 1'b0);
    tick();

    // Three-step command 0 -> 5 -> 9.
    setProg(0, 5, 9, 0, 3, 2'd3, 8'h00);
    AInValid = 1'b1;
    #1;
    chk("t2 pop0", AInPop, 1'b0);
    tick();
    #1;
    chk("t2 step a", AOutStep, 10'd0);
    chk("t2 len a", AOutCmdLen, 2'd0);
    chk("t2 this a", AStepThis, 10'd5);
    chk("t2 pop1", AInPop, 1'b0);
    tick();
    #1;
    chk("t2 step b", AOutStep, 10'd5);
    chk("t2 vliw b", AOutVliw, vliwOf(1, 10'd5));
    chk("t2 len b", AOutCmdLen, 2'd0);
    chk("t2 this b", AStepThis, 10'd9);
    chk("t2 pop2", AInPop, 1'b1);
    tick();
    AInValid = 1'b0;
    #1;
    chk("t2 step c", AOutStep, 10'd9);
    chk("t2 len c", AOutCmdLen, 2'd3);
    chk("t2 this c", AStepThis, 10'd0);
    tick();

    // Backpressure during a four-step command.
    setProg(0, 1, 2, 3, 4, 2'd1, 8'h00);
    AOutReady = 1'b0;
    AInValid  = 1'b1;
    repeat (4) tick();
    #1;
    chk("t3 frozen", AStepThis, 10'd2);
    chk("t3 head", AOutStep, 10'd0);
    chk("t3 valid", AOutValid, 1'b1);
    AOutReady = 1'b1;
    tick();
    #1;
    chk("t3 head1", AOutStep, 10'd1);
    chk("t3 this3", AStepThis, 10'd3);
    chk("t3 pop", AInPop, 1'b1);
    tick();
    AInValid = 1'b0;
    #1;
    chk("t3 head2", AOutStep, 10'd2);
    chk("t3 this0", AStepThis, 10'd0);
    tick();
    #1;
    chk("t3 head3", AOutStep, 10'd3);
    chk("t3 len3", AOutCmdLen, 2'd1);
    tick();
    #1;
    chk("t3 empty", AOutValid, 1'b0);

    // Unity step on channel 0 with the ack three cycles late.
    ACpuType = 2'd0;
    setProg(0, 0, 0, 0, 1, 2'd2, 8'h01);
    AInValid = 1'b1;
    #1;
    chk("t4 req0", AUnityReq, 1'b0);
    chk("t4 pop0", AInPop, 1'b0);
    reqCycles = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      if (AUnityReq) reqCycles++;
      chk("t4 nopop", AInPop, 1'b0);
    end
    tick();
    AUnityAck = 1'b1;
    #1;
    if (AUnityReq) reqCycles++;
    chk("t4 ackpop", AInPop, 1'b1);
    tick();
    AUnityAck = 1'b0;
    AInValid  = 1'b0;
    #1;
    chk("t4 reqCycles", reqCycles, 4);
    chk("t4 reqDrop", AUnityReq, 1'b0);
    chk("t4 outValid", AOutValid, 1'b1);
    chk("t4 outLen", AOutCmdLen, 2'd2);
    chk("t4 outVliw", AOutVliw, vliwOf(0, 10'd0));
    progUnity = 8'h00;
    tick();

    // Flush mid-command at step 5 with two entries buffered and a unity request pending.
    ACpuType  = 2'd1;
    AOutReady = 1'b0;
    setProg(0, 0, 0, 0, 1, 2'd2, 8'h00);
    AInValid = 1'b1;
    tick();
    setProg(0, 5, 9, 0, 3, 2'd1, 8'h02);
    #1;
    chk("t5 pop0", AInPop, 1'b0);
    tick();
    #1;
    chk("t5 this5", AStepThis, 10'd5);
    tick();
    #1;
    chk("t5 req", AUnityReq, 1'b1);
    chk("t5 full", AOutValid, 1'b1);
    AFlush = 1'b1;
    #1;
    chk("t5 flushPop", AInPop, 1'b0);
    tick();
    AFlush   = 1'b0;
    AInValid = 1'b0;
    #1;
    chk("t5 outValid", AOutValid, 1'b0);
    chk("t5 stepThis", AStepThis, 10'd0);
    chk("t5 unityReq", AUnityReq, 1'b0);
    progUnity = 8'h00;
    AOutReady = 1'b1;
    tick();

    // Invalid CPU type: sticky error, cleared only by flush.
    ACpuType = 2'd3;
    AInValid = 1'b1;
    #1;
    chk("t6 pop", AInPop, 1'b0);
    tick();
    #1;
    chk("t6 err", AErrType, 1'b1);
    chk("t6 noAccept", AOutValid, 1'b0);
    ACpuType = 2'd1;
    AInValid = 1'b0;
    tick();
    tick();
    #1;
    chk("t6 sticky", AErrType, 1'b1);
    AFlush = 1'b1;
    tick();
    AFlush = 1'b0;
    #1;
    chk("t6 cleared", AErrType, 1'b0);

    // Irregular ready patterns across back-to-back commands; the model checks every cycle.
    ACpuType = 2'd0;
    setProg(0, 3, 4, 0, 3, 2'd2, 8'h00);
    runCmd(16'b0110_1101_0011_1010, 40);
    setProg(0, 7, 0, 0, 2, 2'd3, 8'h00);
    runCmd(16'b1001_0110_1100_0101, 40);
    ACpuType = 2'd1;
    setProg(0, 1, 0, 0, 2, 2'd1, 8'h00);
    runCmd(16'b0000_1111_0001_0011, 40);
    AOutReady = 1'b1;
    repeat (3) tick();
    #1;
    chk("t7 drained", AOutValid, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
